// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the three RAM clients,
// the arbiter and the single-port RAM macro.
interface mem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 16
);
    logic              boot_en;

    logic              ld_req;
    logic              ld_we;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ready;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ready;
    logic              d_stall;

    logic              i_req;
    logic [31:0]       i_addr;
    logic [31:0]       i_rdata;
    logic              i_ready;
    logic              i_stall;

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;

    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  boot_en,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_ready,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ready, d_stall,
        input  i_req, i_addr,
        output i_rdata, i_ready, i_stall,
        output ram_addr, ram_din, ram_we,
        input  ram_dout,
        output conflict_cnt
    );

    modport master (
        output boot_en,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_ready,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ready, d_stall,
        output i_req, i_addr,
        input  i_rdata, i_ready, i_stall,
        input  ram_addr, ram_din, ram_we,
        output ram_dout,
        input  conflict_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for boot loader, CPU data and
// CPU fetch; one transaction at a time, per-port stalls.
module mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int WC_W =
        (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WC_W-1:0] WC_TOP =
        WC_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        W_NONE,
        W_LD,
        W_D,
        W_I
    } win_t;

    state_t            state_q, state_d;
    win_t              win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  conf_q, conf_d;

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic              ld_ready;
    logic              d_ready;
    logic              i_ready;
    logic [31:0]       d_rdata;
    logic [31:0]       i_rdata;
    logic [31:0]       resp_data;

    // Byte-lane and out-of-range address bits are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{
        bus.ld_addr[1:0], bus.ld_addr[31:ADDR_W+2],
        bus.d_addr[1:0],  bus.d_addr[31:ADDR_W+2],
        bus.i_addr[1:0],  bus.i_addr[31:ADDR_W+2]
    };

    // State, latched transaction and conflict counter.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            win_q   <= W_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wcnt_q  <= '0;
            conf_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            wcnt_q  <= wcnt_d;
            conf_q  <= conf_d;
        end
    end

    // Grant, sequencing and RAM/response drive.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        wcnt_d    = wcnt_q;
        ram_addr  = '0;
        ram_din   = '0;
        ram_we    = 1'b0;
        ld_ready  = 1'b0;
        d_ready   = 1'b0;
        i_ready   = 1'b0;
        d_rdata   = '0;
        i_rdata   = '0;
        resp_data = we_q ? 32'h0 : bus.ram_dout;

        unique case (state_q)
            S_IDLE: begin
                win_d = W_NONE;
                if (bus.boot_en && bus.ld_req) begin
                    win_d   = W_LD;
                    addr_d  = bus.ld_addr[ADDR_W+1:2];
                    wdata_d = bus.ld_wdata;
                    we_d    = bus.ld_we;
                end else if (!bus.boot_en && bus.d_req) begin
                    win_d   = W_D;
                    addr_d  = bus.d_addr[ADDR_W+1:2];
                    wdata_d = bus.d_wdata;
                    we_d    = bus.d_we;
                end else if (!bus.boot_en && bus.i_req) begin
                    win_d   = W_I;
                    addr_d  = bus.i_addr[ADDR_W+1:2];
                    wdata_d = '0;
                    we_d    = 1'b0;
                end
                if (win_d != W_NONE) begin
                    state_d = S_ACCESS;
                    wcnt_d  = WC_TOP;
                end
            end
            S_ACCESS: begin
                ram_addr = addr_q;
                ram_din  = wdata_q;
                ram_we   = we_q && (wcnt_q == WC_TOP);
                if (wcnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q - WC_W'(1);
                end
            end
            S_RESP: begin
                ram_addr = addr_q;
                state_d  = S_IDLE;
                unique case (win_q)
                    W_LD: ld_ready = 1'b1;
                    W_D: begin
                        d_ready = 1'b1;
                        d_rdata = resp_data;
                    end
                    W_I: begin
                        i_ready = 1'b1;
                        i_rdata = resp_data;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating count of idle cycles where d and i collide.
    always_comb begin
        conf_d = conf_q;
        if (state_q == S_IDLE && !bus.boot_en &&
            bus.d_req && bus.i_req && !(&conf_q)) begin
            conf_d = conf_q + CNT_W'(1);
        end
    end

    assign bus.ram_addr     = ram_addr;
    assign bus.ram_din      = ram_din;
    assign bus.ram_we       = ram_we;
    assign bus.ld_ready     = ld_ready;
    assign bus.d_ready      = d_ready;
    assign bus.i_ready      = i_ready;
    assign bus.d_rdata      = d_rdata;
    assign bus.i_rdata      = i_rdata;
    assign bus.conflict_cnt = conf_q;
    assign bus.d_stall      = rst_n & bus.d_req & ~d_ready;
    assign bus.i_stall      = rst_n & bus.i_req & ~i_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default build plus a
// CNT_W=4 build sharing stimulus for saturation.
module tb_mem_arbiter;

    logic sys_clk = 1'b0;
    logic rst_n;

    always #5 sys_clk = ~sys_clk;

    mem_arbiter_if #(.ADDR_W(14), .CNT_W(16)) bus ();
    mem_arbiter_if #(.ADDR_W(14), .CNT_W(4))  bus4 ();

    mem_arbiter #(
        .ADDR_W(14), .RD_LAT(1), .CNT_W(16)
    ) u_dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    mem_arbiter #(
        .ADDR_W(14), .RD_LAT(1), .CNT_W(4)
    ) u_dut4 (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus4)
    );

    // RAM model: read-first, one-cycle read latency.
    logic [31:0] mem [0:16383];
    logic [31:0] dout_q;
    logic        pl_en;
    logic [13:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge sys_clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
        dout_q <= mem[bus.ram_addr];
    end

    assign bus.ram_dout  = dout_q;
    assign bus4.ram_dout = dout_q;
    assign bus4.boot_en  = bus.boot_en;
    assign bus4.ld_req   = bus.ld_req;
    assign bus4.ld_we    = bus.ld_we;
    assign bus4.ld_addr  = bus.ld_addr;
    assign bus4.ld_wdata = bus.ld_wdata;
    assign bus4.d_req    = bus.d_req;
    assign bus4.d_we     = bus.d_we;
    assign bus4.d_addr   = bus.d_addr;
    assign bus4.d_wdata  = bus.d_wdata;
    assign bus4.i_req    = bus.i_req;
    assign bus4.i_addr   = bus.i_addr;

    // Write-strobe monitor.
    int          we_cnt = 0;
    logic [13:0] we_addr = '0;
    always @(posedge sys_clk) begin
        if (bus.ram_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= bus.ram_addr;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [13:0] a,
                           input logic [31:0] d);
        @(negedge sys_clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge sys_clk);
        pl_en   = 1'b0;
    endtask

    // 0=ld 1=d 2=i; stops on the negedge showing ready.
    task automatic wait_rdy(input int which,
                            output int cyc);
        logic r;
        cyc = 0;
        r   = 1'b0;
        do begin
            @(negedge sys_clk);
            cyc++;
            r = (which == 0) ? bus.ld_ready :
                (which == 1) ? bus.d_ready  : bus.i_ready;
        end while (!r && cyc < 20);
        if (!r) chk("timeout", {31'h0, r}, 32'h1);
    endtask

    logic [31:0] exp4 [0:3];
    int cyc;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        exp4[0] = 32'h0000_0013;
        exp4[1] = 32'h1111_1111;
        exp4[2] = 32'h2222_2222;
        exp4[3] = 32'h3333_3333;

        rst_n        = 1'b0;
        pl_en        = 1'b0;
        pl_addr      = '0;
        pl_data      = '0;
        bus.boot_en  = 1'b0;
        bus.ld_req   = 1'b0;
        bus.ld_we    = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_wdata = '0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.i_req    = 1'b0;
        bus.i_addr   = '0;

        preload(14'd4, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            preload(14'(k), exp4[k]);
        end

        chk("rst_ram_addr", 32'(bus.ram_addr), 0);
        chk("rst_ram_we", {31'h0, bus.ram_we}, 0);
        chk("rst_d_ready", {31'h0, bus.d_ready}, 0);
        chk("rst_conf", 32'(bus.conflict_cnt), 0);

        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        chk("idle_ram_addr", 32'(bus.ram_addr), 0);
        chk("idle_i_ready", {31'h0, bus.i_ready}, 0);

        // 1: single fetch
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0010;
        #1;
        chk("t1_stall_idle", {31'h0, bus.i_stall}, 1);
        @(negedge sys_clk);
        chk("t1_ram_addr", 32'(bus.ram_addr), 4);
        chk("t1_stall_acc", {31'h0, bus.i_stall}, 1);
        chk("t1_rdy_acc", {31'h0, bus.i_ready}, 0);
        @(negedge sys_clk);
        chk("t1_rdy", {31'h0, bus.i_ready}, 1);
        chk("t1_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        chk("t1_stall_rsp", {31'h0, bus.i_stall}, 0);
        bus.i_req = 1'b0;
        @(negedge sys_clk);
        chk("t1_rdy_after", {31'h0, bus.i_ready}, 0);
        chk("t1_rdata_after", bus.i_rdata, 0);

        // 2: d write vs fetch contention
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0020;
        bus.d_wdata = 32'h1234_5678;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h0;
        wait_rdy(1, cyc);
        chk("t2_d_lat", 32'(cyc), 2);
        chk("t2_d_rdata", bus.d_rdata, 0);
        chk("t2_i_stall", {31'h0, bus.i_stall}, 1);
        chk("t2_we_cnt", 32'(we_cnt), 1);
        chk("t2_we_addr", 32'(we_addr), 8);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        wait_rdy(2, cyc);
        chk("t2_i_lat", 32'(cyc), 3);
        chk("t2_i_rdata", bus.i_rdata, 32'h13);
        chk("t2_we_once", 32'(we_cnt), 1);
        chk("t2_conf", 32'(bus.conflict_cnt), 1);
        chk("t2_conf4", 32'(bus4.conflict_cnt), 1);
        bus.i_req = 1'b0;
        @(negedge sys_clk);
        chk("t2_mem8", mem[8], 32'h1234_5678);

        // 3: boot mode locks out d
        bus.boot_en  = 1'b1;
        bus.ld_req   = 1'b1;
        bus.ld_we    = 1'b1;
        bus.ld_addr  = 32'h0000_0100;
        bus.ld_wdata = 32'hA5A5_A5A5;
        bus.d_req    = 1'b1;
        bus.d_we     = 1'b0;
        bus.d_addr   = 32'h0000_0100;
        wait_rdy(0, cyc);
        chk("t3_ld_lat", 32'(cyc), 2);
        chk("t3_d_stall", {31'h0, bus.d_stall}, 1);
        bus.ld_req = 1'b0;
        bus.ld_we  = 1'b0;
        @(negedge sys_clk);
        chk("t3_d_stall2", {31'h0, bus.d_stall}, 1);
        chk("t3_ram_idle", 32'(bus.ram_addr), 0);
        @(negedge sys_clk);
        chk("t3_d_locked", {31'h0, bus.d_ready}, 0);
        chk("t3_ram_idle2", 32'(bus.ram_addr), 0);
        bus.boot_en = 1'b0;
        wait_rdy(1, cyc);
        chk("t3_d_lat", 32'(cyc), 2);
        chk("t3_d_rdata", bus.d_rdata, 32'hA5A5_A5A5);
        bus.d_req = 1'b0;

        // 4: streaming d reads, period 3
        @(negedge sys_clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                @(negedge sys_clk);
                cyc++;
                if (!bus.d_ready) begin
                    chk("t4_rdata_gap", bus.d_rdata, 0);
                end
            end while (!bus.d_ready && cyc < 20);
            chk("t4_lat", 32'(cyc), (k == 0) ? 2 : 3);
            chk("t4_rdata", bus.d_rdata, exp4[k]);
            if (k < 3) bus.d_addr = 32'((k + 1) * 4);
            else       bus.d_req  = 1'b0;
        end

        // high and low address bits ignored
        @(negedge sys_clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'hFFFF_000A;
        wait_rdy(1, cyc);
        chk("t4_wrap_lat", 32'(cyc), 2);
        chk("t4_wrap_rdata", bus.d_rdata, 32'h2222_2222);
        bus.d_req = 1'b0;

        // 5: reset during ACCESS
        @(negedge sys_clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_000C;
        @(negedge sys_clk);
        chk("t5_ram_acc", 32'(bus.ram_addr), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_ram_rst", 32'(bus.ram_addr), 0);
        chk("t5_rdy_rst", {31'h0, bus.d_ready}, 0);
        chk("t5_conf_rst", 32'(bus.conflict_cnt), 0);
        @(negedge sys_clk);
        chk("t5_rdy_rst2", {31'h0, bus.d_ready}, 0);
        chk("t5_rdata_rst", bus.d_rdata, 0);
        rst_n = 1'b1;
        wait_rdy(1, cyc);
        chk("t5_lat", 32'(cyc), 2);
        chk("t5_rdata", bus.d_rdata, 32'h3333_3333);
        bus.d_req = 1'b0;

        // 6: 21 contentions, CNT_W=4 saturates
        @(negedge sys_clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h4;
        for (int n = 0; n < 21; n++) begin
            wait_rdy(1, cyc);
            if (n == 10) begin
                chk("t6_i_stall", {31'h0, bus.i_stall}, 1);
            end
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        @(negedge sys_clk);
        chk("t6_conf16", 32'(bus.conflict_cnt), 21);
        chk("t6_conf4", 32'(bus4.conflict_cnt), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
